// File: rtl/score_display_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the score display controller.
package score_display_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SCORE_W    = 14;
  localparam int unsigned BCD_W      = NUM_DIGITS * NIB_W;
  localparam int unsigned ITER_W     = 4;
  localparam int unsigned SHIFT_LAST = SCORE_W - 1;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = 14'd9999;
  localparam logic [NIB_W-1:0]   BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (b[i*NIB_W +: NIB_W] >= 4'd5) r[i*NIB_W +: NIB_W] = b[i*NIB_W +: NIB_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder.sv
// Registered hex-digit to active-low 7-segment decoder (gfedcba); codes 10-15 blank.
module decoder (
  input  logic       clk,
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_ff @(posedge clk) begin
    case (code)
      4'd0:    seg <= 7'b1000000;
      4'd1:    seg <= 7'b1111001;
      4'd2:    seg <= 7'b0100100;
      4'd3:    seg <= 7'b0110000;
      4'd4:    seg <= 7'b0011001;
      4'd5:    seg <= 7'b0010010;
      4'd6:    seg <= 7'b0000010;
      4'd7:    seg <= 7'b1111000;
      4'd8:    seg <= 7'b0000000;
      4'd9:    seg <= 7'b0010000;
      default: seg <= 7'b1111111;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl_bin2bcd_seq.sv
// Sequential binary-to-BCD converter with a one-deep, last-write-wins pending slot.
module bin2bcd_seq
  import score_display_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd
);

  state_e                     state;
  logic [SCORE_W-1:0]         bin_q;
  logic [BCD_W-1:0]           work_q;
  logic [ITER_W-1:0]          iter_q;
  logic                       pend;
  logic [SCORE_W-1:0]         pend_val;
  logic [SCORE_W-1:0]         sat;
  logic [BCD_W+SCORE_W-1:0]   shifted;

  always_comb begin
    sat     = sat_score(score);
    shifted = {add3_nibbles(work_q), bin_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      iter_q   <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      busy     <= 1'b0;
      bcd      <= '0;
    end else begin
      // Updates arriving mid-conversion (including the DONE cycle) are parked.
      if (score_valid && state != IDLE) begin
        pend     <= 1'b1;
        pend_val <= sat;
      end
      case (state)
        IDLE: begin
          if (score_valid || pend) begin
            bin_q  <= score_valid ? sat : pend_val;
            work_q <= '0;
            iter_q <= '0;
            pend   <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {work_q, bin_q} <= shifted;
          iter_q          <= iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(SHIFT_LAST)) state <= DONE;
        end
        DONE: begin
          bcd   <= work_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// 4-digit multiplexed 7-segment score display: BCD conversion, digit scan, anode drive.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LEAD_BLANK  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [3:0]         an,
  output logic [6:0]         seg
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [BCD_W-1:0] disp;
  logic [NIB_W-1:0] nib;
  logic [NIB_W-1:0] code;
  logic             upper_zero;

  bin2bcd_seq u_conv (
    .clk         (clk),
    .rst         (rst),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .bcd         (disp)
  );

  // Digit select with leading-zero blanking; the ones digit is never blanked.
  always_comb begin
    nib        = disp[idx*NIB_W +: NIB_W];
    upper_zero = (disp >> (idx*NIB_W)) == '0;
    code       = nib;
    if (rst) begin
      code = BLANK_CODE;
    end else if (LEAD_BLANK && idx != '0 && upper_zero) begin
      code = BLANK_CODE;
    end
  end

  // an is registered from the same idx the decoder sees, so both change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      an  <= 4'b1111;
    end else begin
      an <= ~(4'b0001 << idx);
      if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  decoder u_dec (
    .clk  (clk),
    .code (code),
    .seg  (seg)
  );

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized and directed bench for score_display_ctrl against a timeline reference model.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] score;
  logic        score_valid;
  logic        busy1, busy0;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display_ctrl #(.REFRESH_DIV(4), .LEAD_BLANK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
    .busy(busy1), .an(an1), .seg(seg1)
  );

  score_display_ctrl #(.REFRESH_DIV(4), .LEAD_BLANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
    .busy(busy0), .an(an0), .seg(seg0)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input int v, input int k, input bit lb);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (lb && k > 0 && v < p) return 7'b1111111;
    return seg_of((v / p) % 10);
  endfunction

  // Reference: displayed value as an integer plus a conversion timeline.
  int         m_t, m_disp, m_conv, m_rem, m_pval;
  bit         m_active, m_pend;
  logic [3:0] e_an;
  logic [6:0] e_seg1, e_seg0;
  logic       e_busy;

  always @(posedge clk) begin
    int k;
    int s;
    s = (int'(score) > 9999) ? 9999 : int'(score);
    if (rst) begin
      m_t = 0; m_disp = 0; m_active = 0; m_pend = 0; m_rem = 0;
      e_an = 4'hF; e_seg1 = 7'h7F; e_seg0 = 7'h7F;
    end else begin
      k = (m_t / 4) % 4;
      e_an = 4'hF;
      e_an[k] = 1'b0;
      e_seg1 = digit_seg(m_disp, k, 1'b1);
      e_seg0 = digit_seg(m_disp, k, 1'b0);
      m_t++;
      if (m_active) begin
        if (score_valid) begin m_pend = 1; m_pval = s; end
        m_rem--;
        if (m_rem == 0) begin m_active = 0; m_disp = m_conv; end
      end else if (score_valid || m_pend) begin
        m_conv = score_valid ? s : m_pval;
        m_pend = 0; m_active = 1; m_rem = 15;
      end
    end
    e_busy = m_active;
  end

  int lowc, highc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check("an_lb1", 32'(an1), 32'(e_an));
    check("an_lb0", 32'(an0), 32'(e_an));
    check("seg_lb1", 32'(seg1), 32'(e_seg1));
    check("seg_lb0", 32'(seg0), 32'(e_seg0));
    check("busy_lb1", 32'(busy1), 32'(e_busy));
    check("busy_lb0", 32'(busy0), 32'(e_busy));
    if (busy1 === 1'b0) lowc++;
    if (busy1 === 1'b1) highc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic strobe(input int v);
    score = 14'(v);
    score_valid = 1'b1;
    cycle();
    score_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    score = '0;
    score_valid = 1'b0;
    run(3);
    check("reset_an", 32'(an1), 32'hF);
    check("reset_seg", 32'(seg1), 32'h7F);
    rst = 1'b0;
    run(40);

    // 1234: busy pulse of 15 cycles, then digits 4/3/2/1
    strobe(1234);
    highc = 0;
    run(16);
    check("busy_len_1234", 32'(highc + 1), 32'd15);
    run(20);

    // 7: leading blanking vs. full display
    strobe(7);
    run(40);

    // 12000 saturates to 9999
    strobe(12000);
    highc = 0;
    run(16);
    check("busy_len_12000", 32'(highc + 1), 32'd15);
    run(20);

    // Back-to-back: 2222 overwritten by 3333 while busy
    strobe(1111);
    lowc = 0;
    run(2);
    strobe(2222);
    run(1);
    strobe(3333);
    run(25);
    check("b2b_busy_low", 32'(lowc), 32'd1);
    run(30);

    // Reset mid-conversion
    strobe(5555);
    run(6);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_busy", 32'(busy1), 32'd0);
    highc = 0;
    run(40);
    check("midrst_no_pending", 32'(highc), 32'd0);

    // Random strobes, gaps (often overlapping a conversion) and occasional resets
    for (int n = 0; n < 150; n++) begin
      int gap;
      int v;
      gap = int'($urandom_range(0, 20));
      run(gap);
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end else begin
        strobe(v);
      end
    end
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
